// File: rtl/aldff_bank.sv
// aldff_bank: LANES independent WIDTH-bit registers. Each lane has a level-sensitive async load,
// a clock enable and a sync reset that exists only when ALDFF_BANK_SRST_EN is defined.
module aldff_bank #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      LANES   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   r,
  input  logic [LANES-1:0]       e,
  input  logic [LANES-1:0]       srst,
  input  logic [LANES-1:0]       aload,
  input  logic [LANES*WIDTH-1:0] d,
  input  logic [LANES*WIDTH-1:0] ad,
  output logic [LANES*WIDTH-1:0] q,
  output logic [LANES-1:0]       ald_flag,
  output logic [7:0]             upd_cnt
);

  localparam int unsigned NUM_W = $clog2(LANES + 1);

  logic [LANES-1:0] srst_eff;

`ifdef ALDFF_BANK_SRST_EN
  assign srst_eff = srst;
`else
  logic unused_srst;
  assign unused_srst = ^srst;
  assign srst_eff    = '0;
`endif

  // A lane takes a clocked update only when no async load is holding it.
  logic [LANES-1:0] upd;
  assign upd = ~aload & (srst_eff | e);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH-1:0] clk_q;
    logic [WIDTH-1:0] clk_d;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] q_lane;
    logic             flag_q;
    logic             ald_set;

    assign ald_set = aload[g] & r;

    // NOTE: next-state logic assigns its default first, so no latch is inferred.
    always_comb begin
      clk_d = clk_q;
      if (srst_eff[g]) begin
        clk_d = RST_VAL;
      end else if (e[g]) begin
        clk_d = d[g*WIDTH +: WIDTH];
      end
    end

    // NOTE: state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge r) begin
      if (!r) begin
        clk_q <= RST_VAL;
      end else if (!aload[g]) begin
        clk_q <= clk_d;
      end
    end

    // The load value is frozen on the falling edge of aload.
    always_ff @(negedge aload[g] or negedge r) begin
      if (!r) begin
        hold_q <= RST_VAL;
      end else begin
        hold_q <= ad[g*WIDTH +: WIDTH];
      end
    end

    // Set asynchronously by a live load (including reset release during a load);
    // cleared by the first clocked update.
    always_ff @(posedge clk or negedge r or posedge ald_set) begin
      if (!r) begin
        flag_q <= 1'b0;
      end else if (ald_set) begin
        flag_q <= 1'b1;
      end else if (upd[g]) begin
        flag_q <= 1'b0;
      end
    end

    always_comb begin
      if (!r) begin
        q_lane = RST_VAL;
      end else if (aload[g]) begin
        q_lane = ad[g*WIDTH +: WIDTH];
      end else if (flag_q) begin
        q_lane = hold_q;
      end else begin
        q_lane = clk_q;
      end
    end

    assign q[g*WIDTH +: WIDTH] = q_lane;
    assign ald_flag[g]         = ald_set | flag_q;
  end

  logic [NUM_W-1:0] upd_num;
  logic [8:0]       cnt_sum;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;

  always_comb begin
    upd_num = '0;
    for (int i = 0; i < LANES; i++) begin
      upd_num = upd_num + NUM_W'(upd[i]);
    end
    cnt_sum = {1'b0, cnt_q} + 9'(upd_num);
    cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign upd_cnt = cnt_q;

endmodule

// File: tb/tb_aldff_bank.sv
// tb_aldff_bank: directed and random stimulus for aldff_bank, with a behavioural lane model
// feeding a scoreboard queue of expected outputs.
module tb_aldff_bank;

  localparam int W = 8;
  localparam int L = 4;
  localparam logic [W-1:0] RV = 8'h00;

`ifdef ALDFF_BANK_SRST_EN
  localparam bit SRST_EN = 1'b1;
`else
  localparam bit SRST_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             r;
  logic [L-1:0]     e;
  logic [L-1:0]     srst;
  logic [L-1:0]     aload;
  logic [L*W-1:0]   d;
  logic [L*W-1:0]   ad;
  logic [L*W-1:0]   q;
  logic [L-1:0]     ald_flag;
  logic [7:0]       upd_cnt;

  always #5 clk = ~clk;

  aldff_bank #(
    .WIDTH  (W),
    .LANES  (L),
    .RST_VAL(RV)
  ) dut (
    .clk     (clk),
    .r       (r),
    .e       (e),
    .srst    (srst),
    .aload   (aload),
    .d       (d),
    .ad      (ad),
    .q       (q),
    .ald_flag(ald_flag),
    .upd_cnt (upd_cnt)
  );

  typedef struct {
    string          tag;
    logic [L*W-1:0] q;
    logic [L-1:0]   flag;
    logic [7:0]     cnt;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] mq[L];
  logic [L-1:0] mflag;
  int           mcnt;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for any change of r, aload or ad.
  task automatic model_async();
    if (!r) begin
      for (int i = 0; i < L; i++) mq[i] = RV;
      mflag = '0;
      mcnt  = 0;
    end else begin
      for (int i = 0; i < L; i++) begin
        if (aload[i]) begin
          mq[i]    = ad[i*W +: W];
          mflag[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_clk();
    int n = 0;
    if (r) begin
      for (int i = 0; i < L; i++) begin
        if (!aload[i]) begin
          if (SRST_EN && srst[i]) begin
            mq[i] = RV; mflag[i] = 1'b0; n++;
          end else if (e[i]) begin
            mq[i] = d[i*W +: W]; mflag[i] = 1'b0; n++;
          end
        end
      end
      mcnt = (mcnt + n > 255) ? 255 : mcnt + n;
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t x;
    x.tag = tag;
    for (int i = 0; i < L; i++) x.q[i*W +: W] = mq[i];
    x.flag = mflag;
    x.cnt  = 8'(mcnt);
    sb.push_back(x);
  endtask

  task automatic pop_cmp();
    exp_t x;
    x = sb.pop_front();
    chk({x.tag, "_q"}, q, x.q);
    chk({x.tag, "_flag"}, 32'(ald_flag), 32'(x.flag));
    chk({x.tag, "_cnt"}, 32'(upd_cnt), 32'(x.cnt));
  endtask

  // One cycle: ad, then aload, then r change in separate instants after the falling
  // clock edge; outputs are checked before and after the following rising edge.
  task automatic step(input logic r_v, input logic [L-1:0] al, input logic [L-1:0] sr,
                      input logic [L-1:0] en, input logic [L*W-1:0] d_v,
                      input logic [L*W-1:0] ad_v, input string tag);
    @(negedge clk);
    ad = ad_v;
    #1 model_async();
    aload = al;
    #1 model_async();
    r = r_v;
    #1 model_async();
    d = d_v; e = en; srst = sr;
    push_exp({tag, "_async"});
    #1 pop_cmp();
    @(posedge clk);
    model_clk();
    push_exp({tag, "_clk"});
    #1 pop_cmp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [L*W-1:0] dv;
    r = 1'b1; aload = '0; ad = '0; d = '0; e = '0; srst = '0;
    for (int i = 0; i < L; i++) mq[i] = RV;
    mflag = '0;
    mcnt  = 0;
    #1 r = 1'b0;
    #1 model_async();

    // Reset overrides a full-bank load; release makes q follow ad at once.
    step(1'b0, 4'hF, 4'h0, 4'h0, 32'h0, 32'hA5A5A5A5, "rst");
    chk("rst_q", q, 32'h00000000);
    chk("rst_flag", 32'(ald_flag), 32'h0);
    chk("rst_cnt", 32'(upd_cnt), 32'h0);
    step(1'b1, 4'hF, 4'h0, 4'h0, 32'h0, 32'hA5A5A5A5, "rel");
    chk("rel_q", q, 32'hA5A5A5A5);
    chk("rel_flag", 32'(ald_flag), 32'hF);
    step(1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 32'hA5A5A5A5, "unload");
    chk("unload_q", q, 32'hA5A5A5A5);
    chk("unload_cnt", 32'(upd_cnt), 32'h0);

    // Single-lane enable.
    step(1'b1, 4'h0, 4'h0, 4'b0001, 32'h0000003C, 32'h0, "en0");
    chk("en0_q", q, 32'hA5A5A53C);
    chk("en0_flag", 32'(ald_flag), 32'hE);
    chk("en0_cnt", 32'(upd_cnt), 32'h1);

    // Load coincident with an enabled edge: the load wins and sticks until the next enable.
    step(1'b1, 4'b0010, 4'h0, 4'b0010, 32'h0000AA00, 32'h00005500, "coin");
    chk("coin_q", q, 32'hA5A5553C);
    chk("coin_cnt", 32'(upd_cnt), 32'h1);
    step(1'b1, 4'b0000, 4'h0, 4'b0000, 32'h0000AA00, 32'h00005500, "coin_hold");
    chk("coin_hold_q", q, 32'hA5A5553C);
    chk("coin_hold_flag", 32'(ald_flag), 32'hE);
    step(1'b1, 4'b0000, 4'h0, 4'b0010, 32'h0000AA00, 32'h00005500, "coin_en");
    chk("coin_en_q", q, 32'hA5A5AA3C);
    chk("coin_en_flag", 32'(ald_flag), 32'hC);
    chk("coin_en_cnt", 32'(upd_cnt), 32'h2);

    // Sync reset against enable on lane 2.
    step(1'b1, 4'h0, 4'h0, 4'b0100, 32'h00770000, 32'h0, "ld77");
    chk("ld77_q", q, 32'hA577AA3C);
    step(1'b1, 4'h0, 4'b0100, 4'b0100, 32'h00120000, 32'h0, "srst");
    chk("srst_q", q, SRST_EN ? 32'hA500AA3C : 32'hA512AA3C);
    chk("srst_cnt", 32'(upd_cnt), 32'h4);

    // Counter saturation: 4 lanes per edge from a count of 4.
    for (int i = 0; i < 70; i++) begin
      dv = $urandom;
      step(1'b1, 4'h0, 4'h0, 4'hF, dv, 32'h0, "sat");
      if (i == 61) chk("sat_252", 32'(upd_cnt), 32'd252);
    end
    chk("sat_255", 32'(upd_cnt), 32'd255);
    chk("sat_q", q, dv);
    chk("sat_flag", 32'(ald_flag), 32'h0);

    // Reset asserted in the middle of a load, then released with the load gone.
    step(1'b1, 4'hF, 4'h0, 4'h0, 32'h0, 32'h11223344, "mid");
    chk("mid_q", q, 32'h11223344);
    step(1'b0, 4'hF, 4'h0, 4'hF, 32'hFFFFFFFF, 32'h11223344, "mid_rst");
    chk("mid_rst_q", q, 32'h00000000);
    chk("mid_rst_cnt", 32'(upd_cnt), 32'h0);
    step(1'b1, 4'h0, 4'h0, 4'h0, 32'hFFFFFFFF, 32'h11223344, "mid_rel");
    chk("mid_rel_q", q, 32'h00000000);
    chk("mid_rel_flag", 32'(ald_flag), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 31) != 0),
           4'($urandom) & 4'($urandom),
           4'($urandom) & 4'($urandom) & 4'($urandom),
           4'($urandom),
           $urandom, $urandom, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
